sdram_avm_mport_bridge: RTL and testbench

- Multi-port successor to the single-port SDRAM Avalon-MM front end.
- NUM_PORTS independent clients issue word reads and writes at user data width. A round-robin arbiter serialises them onto one Avalon-MM master, which drives the Altera SDRAM controller.
- Narrow user words are packed into AVM lanes using byteenable.
- Sits between the audio record/play engines and the SDRAM controller on DE2_115.

---
 rtl/sdram_avm_mport_bridge.sv | 188 ++++++++++++++++++
 tb/tb_sdram_avm_mport_bridge.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_avm_mport_bridge.sv
// Round-robin bridge from NUM_PORTS narrow client word ports onto one Avalon-MM master.
// Define SDRAM_AVM_TIMEOUT_EN to add a per-transaction timeout (TIMEOUT_CYC) reported on o_err.
module sdram_avm_mport_bridge #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned USER_DW   = 16,
    parameter int unsigned AVM_DW    = 32,
    parameter int unsigned AVM_AW    = 25,
    parameter int unsigned ADDR_W    = 32
`ifdef SDRAM_AVM_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           i_read,
    input  logic [NUM_PORTS-1:0]           i_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]    i_addr,
    input  logic [NUM_PORTS*USER_DW-1:0]   i_wdata,
    output logic [USER_DW-1:0]             o_rdata,
    output logic [NUM_PORTS-1:0]           o_done,
    output logic [NUM_PORTS-1:0]           o_err,
    output logic [AVM_AW-1:0]              o_avm_address,
    output logic [AVM_DW/8-1:0]            o_avm_byteenable,
    output logic                           o_avm_chipselect,
    output logic [AVM_DW-1:0]              o_avm_writedata,
    output logic                           o_avm_read,
    output logic                           o_avm_write,
    input  logic [AVM_DW-1:0]              i_avm_readdata,
    input  logic                           i_avm_readdatavalid,
    input  logic                           i_avm_waitrequest
);
    localparam int unsigned LANES = AVM_DW / USER_DW;
    localparam int unsigned LW    = $clog2(LANES);
    localparam int unsigned LWW   = (LW > 0) ? LW : 1;
    localparam int unsigned UB    = USER_DW / 8;
    localparam int unsigned BEW   = AVM_DW / 8;
    localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;
    state_t state, state_n;

    logic [NUM_PORTS-1:0] req;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        port_q;
    logic [PW-1:0]        gnt_port;
    logic                 gnt_valid;
    logic                 gnt_write;
    logic [ADDR_W-1:0]    gnt_addr;
    logic [USER_DW-1:0]   gnt_wdata;
    logic [LWW-1:0]       gnt_lane;
    logic [LWW-1:0]       lane_q;
    logic                 op_write_q;
    logic                 tmo_hit;
    logic                 tmo_fire;
    int unsigned          scan_idx;

    assign req = i_read | i_write;

    // First requesting port at or after the round-robin pointer, wrapping.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_idx = (32'(ptr) + i) % NUM_PORTS;
            if (!gnt_valid && req[PW'(scan_idx)]) begin
                gnt_valid = 1'b1;
                gnt_port  = PW'(scan_idx);
            end
        end
    end

    assign gnt_write = i_write[gnt_port];
    assign gnt_addr  = i_addr[32'(gnt_port) * ADDR_W +: ADDR_W];
    assign gnt_wdata = i_wdata[32'(gnt_port) * USER_DW +: USER_DW];
    assign gnt_lane  = (LANES > 1) ? LWW'(gnt_addr) : '0;

`ifdef SDRAM_AVM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt;

    // Zero on the first ISSUE cycle, then counts every cycle spent waiting on the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE || state == WAIT_DATA) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt >= CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err <= '0;
        end else begin
            o_err <= tmo_fire ? (NUM_PORTS'(1) << port_q) : '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign o_err   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        tmo_fire = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) state_n = ISSUE;
            end
            ISSUE: begin
                if (!i_avm_waitrequest) begin
                    state_n = op_write_q ? DONE : WAIT_DATA;
                end else if (tmo_hit) begin
                    state_n  = DONE;
                    tmo_fire = 1'b1;
                end
            end
            WAIT_DATA: begin
                if (i_avm_readdatavalid) begin
                    state_n = DONE;
                end else if (tmo_hit) begin
                    state_n  = DONE;
                    tmo_fire = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Transaction latch at grant, Avalon strobes, completion pulse and read lane capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr              <= '0;
            port_q           <= '0;
            lane_q           <= '0;
            op_write_q       <= 1'b0;
            o_rdata          <= '0;
            o_done           <= '0;
            o_avm_address    <= '0;
            o_avm_byteenable <= '0;
            o_avm_chipselect <= 1'b0;
            o_avm_writedata  <= '0;
            o_avm_read       <= 1'b0;
            o_avm_write      <= 1'b0;
        end else begin
            o_done <= '0;
            if (state == IDLE && gnt_valid) begin
                port_q           <= gnt_port;
                lane_q           <= gnt_lane;
                op_write_q       <= gnt_write;
                o_avm_address    <= AVM_AW'(gnt_addr >> LW);
                o_avm_byteenable <= BEW'({UB{1'b1}}) << (32'(gnt_lane) * UB);
                o_avm_writedata  <= {LANES{gnt_wdata}};
                o_avm_chipselect <= 1'b1;
                o_avm_read       <= !gnt_write;
                o_avm_write      <= gnt_write;
            end else if (state_n != ISSUE) begin
                o_avm_chipselect <= 1'b0;
                o_avm_read       <= 1'b0;
                o_avm_write      <= 1'b0;
            end
            if (state != DONE && state_n == DONE) begin
                o_done <= NUM_PORTS'(1) << port_q;
                if (state == WAIT_DATA && i_avm_readdatavalid) begin
                    o_rdata <= USER_DW'(i_avm_readdata >> (32'(lane_q) * USER_DW));
                end else if (tmo_fire && !op_write_q) begin
                    o_rdata <= '0;
                end
            end
            if (state == DONE) begin
                ptr <= (32'(port_q) == NUM_PORTS - 1) ? '0 : port_q + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sdram_avm_mport_bridge.sv
// Self-checking bench for sdram_avm_mport_bridge: directed cases, randomized transactions
// against a behavioural Avalon slave and expectation model; timeout case when SDRAM_AVM_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_sdram_avm_mport_bridge;
    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     i_read;
    logic [NP-1:0]     i_write;
    logic [NP*32-1:0]  i_addr;
    logic [NP*16-1:0]  i_wdata;
    logic [15:0]       o_rdata;
    logic [NP-1:0]     o_done;
    logic [NP-1:0]     o_err;
    logic [24:0]       o_avm_address;
    logic [3:0]        o_avm_byteenable;
    logic              o_avm_chipselect;
    logic [31:0]       o_avm_writedata;
    logic              o_avm_read;
    logic              o_avm_write;
    logic [31:0]       i_avm_readdata;
    logic              i_avm_readdatavalid;
    logic              i_avm_waitrequest;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] last_rdata;

    // Observations of the most recent run_txn
    int          obs_done_cnt, obs_done_idx, obs_rd_cyc, obs_wr_cyc;
    logic [NP-1:0] obs_done_mask, obs_err_mask;
    logic [15:0] obs_rdata;
    logic [24:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd;
    bit          obs_unstable;

    always #5 clk = ~clk;

`ifdef SDRAM_AVM_TIMEOUT_EN
    sdram_avm_mport_bridge #(.NUM_PORTS(NP), .USER_DW(16), .AVM_DW(32), .AVM_AW(25), .ADDR_W(32), .TIMEOUT_CYC(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_read              (i_read),
        .i_write             (i_write),
        .i_addr              (i_addr),
        .i_wdata             (i_wdata),
        .o_rdata             (o_rdata),
        .o_done              (o_done),
        .o_err               (o_err),
        .o_avm_address       (o_avm_address),
        .o_avm_byteenable    (o_avm_byteenable),
        .o_avm_chipselect    (o_avm_chipselect),
        .o_avm_writedata     (o_avm_writedata),
        .o_avm_read          (o_avm_read),
        .o_avm_write         (o_avm_write),
        .i_avm_readdata      (i_avm_readdata),
        .i_avm_readdatavalid (i_avm_readdatavalid),
        .i_avm_waitrequest   (i_avm_waitrequest)
    );
`else
    sdram_avm_mport_bridge #(.NUM_PORTS(NP), .USER_DW(16), .AVM_DW(32), .AVM_AW(25), .ADDR_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_read              (i_read),
        .i_write             (i_write),
        .i_addr              (i_addr),
        .i_wdata             (i_wdata),
        .o_rdata             (o_rdata),
        .o_done              (o_done),
        .o_err               (o_err),
        .o_avm_address       (o_avm_address),
        .o_avm_byteenable    (o_avm_byteenable),
        .o_avm_chipselect    (o_avm_chipselect),
        .o_avm_writedata     (o_avm_writedata),
        .o_avm_read          (o_avm_read),
        .o_avm_write         (o_avm_write),
        .i_avm_readdata      (i_avm_readdata),
        .i_avm_readdatavalid (i_avm_readdatavalid),
        .i_avm_waitrequest   (i_avm_waitrequest)
    );
`endif

    // One client transaction against a slave that stalls wait_cyc issue cycles and
    // returns read data rdv_dly cycles after acceptance; index 1 is the first edge after request.
    task automatic run_txn(input int port, input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [15:0] wd, input int wait_cyc, input int rdv_dly,
                           input logic [31:0] rword);
        int issue_seen = 0;
        int acc_idx    = -1;
        int stop_idx   = -1;
        obs_done_cnt = 0; obs_done_idx = -1; obs_rd_cyc = 0; obs_wr_cyc = 0;
        obs_done_mask = '0; obs_err_mask = '0; obs_rdata = '0;
        obs_addr = '0; obs_be = '0; obs_wd = '0; obs_unstable = 1'b0;
        i_read[port]  = rd;
        i_write[port] = wr;
        i_addr[port*32 +: 32]  = addr;
        i_wdata[port*16 +: 16] = wd;
        i_avm_waitrequest   = 1'b1;
        i_avm_readdatavalid = 1'b0;
        for (int idx = 1; idx <= 60; idx++) begin
            @(posedge clk); #1;
            i_avm_readdatavalid = 1'b0;
            i_avm_readdata      = $urandom;
            if (o_err != 0) obs_err_mask |= o_err;
            if (o_avm_chipselect) begin
                if (issue_seen == 0) begin
                    obs_addr = o_avm_address; obs_be = o_avm_byteenable; obs_wd = o_avm_writedata;
                end else if (obs_addr !== o_avm_address || obs_be !== o_avm_byteenable ||
                             obs_wd !== o_avm_writedata) begin
                    obs_unstable = 1'b1;
                end
                issue_seen++;
                i_avm_waitrequest = (issue_seen <= wait_cyc);
                if (!i_avm_waitrequest) acc_idx = idx;
            end else begin
                i_avm_waitrequest = 1'b1;
            end
            if (o_avm_read)  obs_rd_cyc++;
            if (o_avm_write) obs_wr_cyc++;
            if (rd && !wr && acc_idx > 0 && idx == acc_idx + rdv_dly) begin
                i_avm_readdatavalid = 1'b1;
                i_avm_readdata      = rword;
            end
            if (obs_done_cnt > 0 && idx == obs_done_idx + 1) begin
                i_read[port]  = 1'b0;
                i_write[port] = 1'b0;
            end
            if (o_done != 0) begin
                obs_done_cnt++;
                obs_done_mask |= o_done;
                obs_rdata    = o_rdata;
                obs_done_idx = idx;
                stop_idx     = idx + 3;
            end
            if (idx == stop_idx) break;
        end
        i_read  = '0;
        i_write = '0;
        i_avm_waitrequest   = 1'b1;
        i_avm_readdatavalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_read = '0; i_write = '0; i_addr = '0; i_wdata = '0;
        i_avm_readdata = '0; i_avm_readdatavalid = 1'b0; i_avm_waitrequest = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_rdata, o_done, o_err, o_avm_address, o_avm_byteenable, o_avm_chipselect,
             o_avm_writedata, o_avm_read, o_avm_write} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdata=%h done=%b addr=%h be=%b cs=%b rd=%b wr=%b, want all 0",
                     o_rdata, o_done, o_avm_address, o_avm_byteenable, o_avm_chipselect,
                     o_avm_read, o_avm_write);
        end
        rst = 1'b0;
        last_rdata = '0;
    endtask

    task automatic test_write_basic;
        run_txn(0, 1'b1, 1'b0, 32'h5, 16'hBEEF, 0, 1, 32'h0);
        n_checks++; if (obs_addr !== 25'd2) begin n_fail++; $display("FAIL wr_addr: got %h want 2", obs_addr); end
        n_checks++; if (obs_be !== 4'b1100) begin n_fail++; $display("FAIL wr_be: got %b want 1100", obs_be); end
        n_checks++; if (obs_wd !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL wr_data: got %h want beefbeef", obs_wd); end
        n_checks++; if (obs_wr_cyc != 1 || obs_rd_cyc != 0) begin n_fail++; $display("FAIL wr_strobes: wr=%0d rd=%0d want 1/0", obs_wr_cyc, obs_rd_cyc); end
        n_checks++; if (obs_done_cnt != 1 || obs_done_mask !== 2'b01) begin n_fail++; $display("FAIL wr_done: cnt=%0d mask=%b want 1/01", obs_done_cnt, obs_done_mask); end
        n_checks++; if (obs_done_idx != 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", obs_done_idx); end
        n_checks++; if (obs_err_mask !== 2'b00) begin n_fail++; $display("FAIL wr_err: got %b want 00", obs_err_mask); end
    endtask

    task automatic test_read_wait;
        run_txn(1, 1'b0, 1'b1, 32'h4, 16'h0, 3, 2, 32'h1234ABCD);
        n_checks++; if (obs_rd_cyc != 4 || obs_wr_cyc != 0) begin n_fail++; $display("FAIL rd_held: rd=%0d wr=%0d want 4/0", obs_rd_cyc, obs_wr_cyc); end
        n_checks++; if (obs_be !== 4'b0011) begin n_fail++; $display("FAIL rd_be: got %b want 0011", obs_be); end
        n_checks++; if (obs_addr !== 25'd2) begin n_fail++; $display("FAIL rd_addr: got %h want 2", obs_addr); end
        n_checks++; if (obs_unstable) begin n_fail++; $display("FAIL rd_stable: got unstable want stable"); end
        n_checks++; if (obs_rdata !== 16'hABCD) begin n_fail++; $display("FAIL rd_data: got %h want abcd", obs_rdata); end
        n_checks++; if (obs_done_cnt != 1 || obs_done_mask !== 2'b10) begin n_fail++; $display("FAIL rd_done: cnt=%0d mask=%b want 1/10", obs_done_cnt, obs_done_mask); end
        n_checks++; if (obs_done_idx != 7) begin n_fail++; $display("FAIL rd_latency: got %0d want 7", obs_done_idx); end
        last_rdata = 16'hABCD;
    endtask

    task automatic test_read_write_same;
        run_txn(0, 1'b1, 1'b1, 32'h0, 16'h5A5A, 1, 1, 32'hFFFF0000);
        n_checks++; if (obs_wr_cyc != 2 || obs_rd_cyc != 0) begin n_fail++; $display("FAIL rw_strobes: wr=%0d rd=%0d want 2/0", obs_wr_cyc, obs_rd_cyc); end
        n_checks++; if (obs_done_cnt != 1 || obs_done_mask !== 2'b01) begin n_fail++; $display("FAIL rw_done: cnt=%0d mask=%b want 1/01", obs_done_cnt, obs_done_mask); end
        n_checks++; if (obs_wd !== 32'h5A5A5A5A || obs_be !== 4'b0011) begin n_fail++; $display("FAIL rw_data: wd=%h be=%b want 5a5a5a5a/0011", obs_wd, obs_be); end
        n_checks++; if (obs_rdata !== last_rdata) begin n_fail++; $display("FAIL rw_rdata_hold: got %h want %h", obs_rdata, last_rdata); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 24; it++) begin
            int          port  = $urandom_range(0, 1);
            int          op    = $urandom_range(0, 2);
            logic [31:0] addr  = $urandom;
            logic [15:0] wd    = 16'($urandom);
            int          w     = $urandom_range(0, 3);
            int          d     = $urandom_range(1, 3);
            logic [31:0] rword = $urandom;
            bit          wr    = (op != 0);
            bit          rd    = (op != 1);
            int          lane  = addr % 2;
            logic [24:0] exp_addr = 25'(addr >> 1);
            logic [3:0]  exp_be   = 4'(3 << (2 * lane));
            logic [31:0] exp_wd   = {wd, wd};
            logic [15:0] exp_rd   = wr ? last_rdata : 16'(rword >> (16 * lane));
            int          exp_idx  = wr ? 2 + w : 2 + w + d;
            if (it % 2 == 1) begin
                i_avm_readdatavalid = 1'b1;
                i_avm_readdata      = $urandom;
                @(posedge clk); #1;
                i_avm_readdatavalid = 1'b0;
            end
            run_txn(port, wr, rd, addr, wd, w, d, rword);
            n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h want %h", it, obs_addr, exp_addr); end
            n_checks++; if (obs_be !== exp_be) begin n_fail++; $display("FAIL rand_be[%0d]: got %b want %b", it, obs_be, exp_be); end
            if (wr) begin
                n_checks++; if (obs_wd !== exp_wd) begin n_fail++; $display("FAIL rand_wd[%0d]: got %h want %h", it, obs_wd, exp_wd); end
            end
            n_checks++;
            if (obs_wr_cyc != (wr ? w + 1 : 0) || obs_rd_cyc != (wr ? 0 : w + 1)) begin
                n_fail++; $display("FAIL rand_strobes[%0d]: wr=%0d rd=%0d wait=%0d write=%0b", it, obs_wr_cyc, obs_rd_cyc, w, wr);
            end
            n_checks++;
            if (obs_done_cnt != 1 || obs_done_mask !== 2'(1 << port)) begin
                n_fail++; $display("FAIL rand_done[%0d]: cnt=%0d mask=%b want 1 pulse on port %0d", it, obs_done_cnt, obs_done_mask, port);
            end
            n_checks++; if (obs_done_idx != exp_idx) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, obs_done_idx, exp_idx); end
            n_checks++; if (obs_rdata !== exp_rd) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", it, obs_rdata, exp_rd); end
            n_checks++; if (obs_err_mask !== 2'b00 || obs_unstable) begin n_fail++; $display("FAIL rand_err_stable[%0d]: err=%b unstable=%0b want 00/0", it, obs_err_mask, obs_unstable); end
            last_rdata = exp_rd;
        end
    endtask

    // Both ports keep re-requesting together; grants must alternate from port 0.
    task automatic test_back_to_back;
        logic [31:0] addr_a [NP];
        logic [24:0] cur_addr = '0;
        int  exp_port = 0;
        int  n_done   = 0;
        bit  drop     = 1'b0;
        bit  reassert = 1'b0;
        bit  cs_seen  = 1'b0;
        rst = 1'b1;
        i_avm_waitrequest = 1'b0;
        for (int p = 0; p < NP; p++) begin
            addr_a[p] = $urandom;
            i_addr[p*32 +: 32] = addr_a[p];
        end
        i_write = '1;
        i_read  = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 200 && n_done < 8; c++) begin
            @(posedge clk); #1;
            if (reassert) begin
                for (int p = 0; p < NP; p++) begin
                    addr_a[p] = $urandom;
                    i_addr[p*32 +: 32] = addr_a[p];
                end
                i_write  = '1;
                reassert = 1'b0;
            end
            if (drop) begin
                i_write  = '0;
                drop     = 1'b0;
                reassert = 1'b1;
            end
            if (o_avm_chipselect && !cs_seen) begin
                cur_addr = o_avm_address;
                cs_seen  = 1'b1;
            end
            if (o_done != 0) begin
                n_checks++;
                if (o_done !== 2'(1 << exp_port)) begin
                    n_fail++; $display("FAIL b2b_grant[%0d]: got %b want %b", n_done, o_done, 2'(1 << exp_port));
                end
                n_checks++;
                if (cur_addr !== 25'(addr_a[exp_port] >> 1)) begin
                    n_fail++; $display("FAIL b2b_addr[%0d]: got %h want %h", n_done, cur_addr, 25'(addr_a[exp_port] >> 1));
                end
                exp_port = (exp_port + 1) % NP;
                n_done++;
                drop    = 1'b1;
                cs_seen = 1'b0;
            end
        end
        n_checks++;
        if (n_done != 8) begin n_fail++; $display("FAIL b2b_count: got %0d completions want 8", n_done); end
        i_write = '0;
        i_avm_waitrequest = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        last_rdata = '0;
    endtask

    task automatic test_reset_wait_data;
        bit bad = 1'b0;
        i_read[1] = 1'b1;
        i_addr[32 +: 32] = 32'h4;
        i_avm_waitrequest   = 1'b0;
        i_avm_readdatavalid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (o_avm_read !== 1'b1) begin n_fail++; $display("FAIL rstw_issue: read=%b want 1", o_avm_read); end
        @(posedge clk); #1;
        n_checks++; if (o_avm_read !== 1'b0) begin n_fail++; $display("FAIL rstw_read_drop: read=%b want 0", o_avm_read); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_rdata, o_done, o_err, o_avm_address, o_avm_byteenable, o_avm_chipselect,
             o_avm_writedata, o_avm_read, o_avm_write} !== '0) begin
            n_fail++; $display("FAIL rstw_outputs: done=%b cs=%b rd=%b addr=%h want all 0", o_done, o_avm_chipselect, o_avm_read, o_avm_address);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        i_read = '0;
        i_avm_readdatavalid = 1'b1;
        i_avm_readdata      = 32'hCAFEF00D;
        repeat (4) begin
            @(posedge clk); #1;
            i_avm_readdatavalid = 1'b0;
            if (o_done != 0 || o_avm_chipselect || o_avm_read || o_avm_write || o_rdata != 0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL rstw_late_rdv: got activity after reset want none"); end
        last_rdata = '0;
        run_txn(0, 1'b1, 1'b0, 32'h3, 16'h1357, 0, 1, 32'h0);
        n_checks++;
        if (obs_done_idx != 2 || obs_done_mask !== 2'b01) begin
            n_fail++; $display("FAIL rstw_idle_after: latency=%0d mask=%b want 2/01", obs_done_idx, obs_done_mask);
        end
    endtask

`ifdef SDRAM_AVM_TIMEOUT_EN
    task automatic test_timeout;
        run_txn(1, 1'b0, 1'b1, 32'h7, 16'h0, 0, 1000, 32'h0);
        n_checks++; if (obs_done_idx != 9) begin n_fail++; $display("FAIL tmo_rd_latency: got %0d want 9", obs_done_idx); end
        n_checks++; if (obs_done_mask !== 2'b10 || obs_err_mask !== 2'b10) begin n_fail++; $display("FAIL tmo_rd_flags: done=%b err=%b want 10/10", obs_done_mask, obs_err_mask); end
        n_checks++; if (obs_rdata !== 16'h0) begin n_fail++; $display("FAIL tmo_rd_data: got %h want 0", obs_rdata); end
        run_txn(0, 1'b1, 1'b0, 32'h2, 16'h2468, 100, 1, 32'h0);
        n_checks++; if (obs_done_idx != 9 || obs_wr_cyc != 8) begin n_fail++; $display("FAIL tmo_wr: latency=%0d wr_cyc=%0d want 9/8", obs_done_idx, obs_wr_cyc); end
        n_checks++; if (obs_err_mask !== 2'b01) begin n_fail++; $display("FAIL tmo_wr_err: got %b want 01", obs_err_mask); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_read_write_same();
        test_random();
        test_back_to_back();
        test_reset_wait_data();
`ifdef SDRAM_AVM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
